// File: rtl/agc_timing_core.sv
// ============================================================================
// agc_timing_core
// ----------------------------------------------------------------------------
// Reduced AGC timing/start sequencer. The slow AGC oscillator (CLOCK) is
// brought into the SIM_CLK domain and each of its rising edges becomes a
// single-cycle tick. Ticks drive a general-start (GOJAM) countdown, then a
// one-hot T01..T12 timing-pulse ring, and count completed memory cycles.
// Monitor start/stop and the hardware restart are honoured on top of that.
//
// Ports:
//   SIM_CLK  in   system clock, all state changes on its rising edge
//   SIM_RST  in   synchronous active-high reset
//   CLOCK    in   AGC oscillator, asynchronous, period >= 8 SIM_CLK
//   MSTRT    in   monitor start request (asynchronous, edge-sensitive)
//   MSTP     in   monitor stop request (asynchronous level)
//   STRT2    in   hardware restart (asynchronous level)
//   MGOJAM   out  general start active
//   MT       out  one-hot timing pulse, MT[0]=T01 .. MT[11]=T12
//   MCT      out  completed memory-cycle count (wraps)
//   RUNNING  out  high while the timing ring is running
//
// Parameters:
//   GOJAM_TICKS  CLOCK rises MGOJAM is held after reset/restart (1..255)
//   MCT_W        width of the memory-cycle counter
//
// Build option:
//   MONITOR_STEP_EN  when defined, an MSTRT edge while stopped with MSTP
//                    still asserted single-steps one memory cycle instead
//                    of forcing a general start.
// ============================================================================
module agc_timing_core #(
    parameter int GOJAM_TICKS = 12,
    parameter int MCT_W       = 16
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             CLOCK,
    input  logic             MSTRT,
    input  logic             MSTP,
    input  logic             STRT2,
    output logic             MGOJAM,
    output logic [11:0]      MT,
    output logic [MCT_W-1:0] MCT,
    output logic             RUNNING
);

    typedef enum logic [1:0] {
        ST_JAM     = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    localparam logic [7:0]       JAM_LOAD = 8'(GOJAM_TICKS);
    localparam logic [11:0]      T01      = 12'h001;
    localparam logic [MCT_W-1:0] MCT_ONE  = {{(MCT_W-1){1'b0}}, 1'b1};

    // Synchroniser chains: bit 0 is the metastability catcher, bit 1 is the
    // usable synchronised value. The *Prev flops hold the previous
    // synchronised value for edge detection.
    logic [1:0] clockSync_q;
    logic [1:0] mstrtSync_q;
    logic [1:0] mstpSync_q;
    logic [1:0] strt2Sync_q;
    logic       clockPrev_q;
    logic       mstrtPrev_q;

    state_e            state_q;
    logic [7:0]        jamCnt_q;
    logic [11:0]       mt_q;
    logic [MCT_W-1:0]  mct_q;
    logic              mgojam_q;
    logic              running_q;

    logic tick;
    logic mstrtEdge;
    logic mstpSync;
    logic strt2Sync;
    logic stepReq;

    // Bring all asynchronous inputs into the SIM_CLK domain.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            clockSync_q <= 2'b00;
            mstrtSync_q <= 2'b00;
            mstpSync_q  <= 2'b00;
            strt2Sync_q <= 2'b00;
            clockPrev_q <= 1'b0;
            mstrtPrev_q <= 1'b0;
        end else begin
            clockSync_q <= {clockSync_q[0], CLOCK};
            mstrtSync_q <= {mstrtSync_q[0], MSTRT};
            mstpSync_q  <= {mstpSync_q[0], MSTP};
            strt2Sync_q <= {strt2Sync_q[0], STRT2};
            clockPrev_q <= clockSync_q[1];
            mstrtPrev_q <= mstrtSync_q[1];
        end
    end

    assign tick      = clockSync_q[1] & ~clockPrev_q;
    assign mstrtEdge = mstrtSync_q[1] & ~mstrtPrev_q;
    assign mstpSync  = mstpSync_q[1];
    assign strt2Sync = strt2Sync_q[1];

    // A step request is an MSTRT edge that arrives while parked with MSTP
    // still held; only meaningful when single-stepping is built in.
`ifdef MONITOR_STEP_EN
    assign stepReq = mstrtEdge & mstpSync & (state_q == ST_STOPPED);
`else
    assign stepReq = 1'b0;
`endif

    // Sequencer. Restarts take precedence over everything but reset and
    // swallow any tick that lands on the same edge, so an interrupted memory
    // cycle never reaches the count. Otherwise each tick advances the
    // countdown, the pulse ring or the stopped state. A single step enters
    // RUN at T01 and relies on the normal T12 MSTP check to park again.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q   <= ST_JAM;
            jamCnt_q  <= JAM_LOAD;
            mt_q      <= '0;
            mct_q     <= '0;
            mgojam_q  <= 1'b1;
            running_q <= 1'b0;
        end else if (strt2Sync || (mstrtEdge && !stepReq)) begin
            state_q   <= ST_JAM;
            jamCnt_q  <= JAM_LOAD;
            mt_q      <= '0;
            mgojam_q  <= 1'b1;
            running_q <= 1'b0;
        end else if (stepReq) begin
            state_q   <= ST_RUN;
            mt_q      <= T01;
            mgojam_q  <= 1'b0;
            running_q <= 1'b1;
        end else if (tick) begin
            case (state_q)
                ST_JAM: begin
                    if (jamCnt_q <= 8'd1) begin
                        jamCnt_q  <= 8'd0;
                        state_q   <= ST_RUN;
                        mt_q      <= T01;
                        mgojam_q  <= 1'b0;
                        running_q <= 1'b1;
                    end else begin
                        jamCnt_q <= jamCnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    // T12 closes a memory cycle; only here may MSTP park us.
                    if (mt_q[11]) begin
                        mct_q <= mct_q + MCT_ONE;
                        if (mstpSync) begin
                            state_q   <= ST_STOPPED;
                            mt_q      <= '0;
                            running_q <= 1'b0;
                        end else begin
                            mt_q <= T01;
                        end
                    end else begin
                        mt_q <= {mt_q[10:0], 1'b0};
                    end
                end
                ST_STOPPED: begin
                    if (!mstpSync) begin
                        state_q   <= ST_RUN;
                        mt_q      <= T01;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_JAM;
                    jamCnt_q  <= JAM_LOAD;
                    mt_q      <= '0;
                    mgojam_q  <= 1'b1;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign MGOJAM  = mgojam_q;
    assign MT      = mt_q;
    assign MCT     = mct_q;
    assign RUNNING = running_q;

endmodule

// File: tb/tb_agc_timing_core.sv
// ============================================================================
// tb_agc_timing_core
// ----------------------------------------------------------------------------
// Self-checking bench for agc_timing_core. Every CLOCK period is split into a
// low phase (control inputs change, restart effects settle) and a high phase
// (one tick). Outputs are compared at the end of each phase against a model
// that tracks "GOJAM ticks left", "current timing pulse number" and the
// cycle count as plain integers. A narrow MCT instance makes counter wrap
// reachable in a short run. Directed segments are followed by random ones.
// ============================================================================
module tb_agc_timing_core;

    localparam int GOJAM   = 12;
    localparam int MCT_W   = 4;
    localparam int MCT_MOD = 1 << MCT_W;

    logic             SIM_CLK;
    logic             SIM_RST;
    logic             CLOCK;
    logic             MSTRT;
    logic             MSTP;
    logic             STRT2;
    logic             MGOJAM;
    logic [11:0]      MT;
    logic [MCT_W-1:0] MCT;
    logic             RUNNING;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: ticks of general start still owed, active
    // timing pulse number (0 = none, 1..12 = T01..T12), completed cycles.
    int jamLeft;
    int pulse;
    int cycles;
    bit mMstp;
    bit mStrt2;

    agc_timing_core #(
        .GOJAM_TICKS(GOJAM),
        .MCT_W      (MCT_W)
    ) dut (
        .SIM_CLK(SIM_CLK),
        .SIM_RST(SIM_RST),
        .CLOCK  (CLOCK),
        .MSTRT  (MSTRT),
        .MSTP   (MSTP),
        .STRT2  (STRT2),
        .MGOJAM (MGOJAM),
        .MT     (MT),
        .MCT    (MCT),
        .RUNNING(RUNNING)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expMt();
        if (pulse == 0 || jamLeft > 0) return 32'd0;
        return 32'd1 << (pulse - 1);
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ":MT"}, 32'(MT), expMt());
        checkOutput({tag, ":MGOJAM"}, 32'(MGOJAM), (jamLeft > 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ":MCT"}, 32'(MCT), 32'(cycles));
        checkOutput({tag, ":RUNNING"}, 32'(RUNNING),
                    (jamLeft == 0 && pulse != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic modelRestart();
        jamLeft = GOJAM;
        pulse   = 0;
    endtask

    task automatic modelTick();
        if (mStrt2) begin
            modelRestart();
        end else if (jamLeft > 0) begin
            jamLeft--;
            if (jamLeft == 0) pulse = 1;
        end else if (pulse == 0) begin
            if (!mMstp) pulse = 1;
        end else if (pulse == 12) begin
            cycles = (cycles + 1) % MCT_MOD;
            pulse  = mMstp ? 0 : 1;
        end else begin
            pulse++;
        end
    endtask

    // One full CLOCK period: set controls (optionally a 5-cycle MSTRT pulse)
    // during the low phase and check, then raise CLOCK and check again.
    task automatic applyStimulus(input bit mstpV, input bit strt2V, input bit pulseM);
        bit stepOk;
        @(negedge SIM_CLK);
        MSTP  = mstpV;
        STRT2 = strt2V;
        MSTRT = pulseM;
        mMstp  = mstpV;
        mStrt2 = strt2V;
`ifdef MONITOR_STEP_EN
        stepOk = (jamLeft == 0 && pulse == 0 && mstpV);
`else
        stepOk = 1'b0;
`endif
        if (strt2V) begin
            modelRestart();
        end else if (pulseM) begin
            if (stepOk) pulse = 1;
            else modelRestart();
        end
        repeat (5) @(negedge SIM_CLK);
        MSTRT = 1'b0;
        repeat (7) @(negedge SIM_CLK);
        checkAll("low");
        CLOCK = 1'b1;
        modelTick();
        repeat (12) @(negedge SIM_CLK);
        checkAll("high");
        CLOCK = 1'b0;
    endtask

    initial begin
        bit rM;
        bit rS;
        bit pm;
        int guard;

        SIM_RST = 1'b1;
        CLOCK   = 1'b0;
        MSTRT   = 1'b0;
        MSTP    = 1'b0;
        STRT2   = 1'b0;
        jamLeft = GOJAM;
        pulse   = 0;
        cycles  = 0;
        mMstp   = 1'b0;
        mStrt2  = 1'b0;

        repeat (10) @(negedge SIM_CLK);
        checkAll("reset");
        SIM_RST = 1'b0;
        $display("[TB] reset released");

        // Power-up general start, then five full memory cycles.
        repeat (GOJAM + 5 * 12) applyStimulus(1'b0, 1'b0, 1'b0);

        // Monitor start while running: general start again, count held.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (GOJAM + 2) applyStimulus(1'b0, 1'b0, 1'b0);

        // MSTP raised at T05 only takes effect at the end of the cycle.
        guard = 0;
        while (pulse != 5 && guard < 30) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("reachT05", 32'(pulse), 32'd5);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Held hardware restart, then the full countdown after release.
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (GOJAM + 3) applyStimulus(1'b0, 1'b0, 1'b0);

        // Enough cycles to wrap the narrow cycle counter.
        repeat ((MCT_MOD + 2) * 12) applyStimulus(1'b0, 1'b0, 1'b0);

        // Park with MSTP held, then request a start while parked.
        guard = 0;
        while (!(jamLeft == 0 && pulse == 0) && guard < 30) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("parked", 32'(pulse), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (14) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (GOJAM + 2) applyStimulus(1'b0, 1'b0, 1'b0);

        // Random control traffic.
        rM = 1'b0;
        rS = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) rM = !rM;
            if (rS) begin
                if ($urandom_range(2) == 0) rS = 1'b0;
            end else if ($urandom_range(39) == 0) begin
                rS = 1'b1;
            end
            pm = ($urandom_range(29) == 0);
            applyStimulus(rM, rS, pm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
